img_frame_arbiter: RTL and testbench
====================================

// Module: img_frame_arbiter
// PURPOSE
//  Shares one gray-scale filter pipeline (e.g. gaussian_filter_proc) between N_SRC video sources on whole-frame granularity.
//  Each source requests a frame slot, gets a grant, streams one vsync/href/gray frame, and receives the filtered frame back.
//  Sits between the capture sources and the filter; the filter never sees interleaved frames.
// PARAMETERS
//  N_SRC          2     number of requesting sources (>=2)
//  DATA_W         8     pixel width
//  TIMEOUT_CYCLES 4096  drain watchdog limit (used only with FRAME_TIMEOUT_EN)
// PORTS
//  clk            in   1              clock
//  rst_n          in   1              reset, synchronous, active-low
//  src_req        in   N_SRC          per-source frame request, level
//  src_gnt        out  N_SRC          one-hot grant, level
//  src_vsync      in   N_SRC          per-source frame-valid
//  src_href       in   N_SRC          per-source line-valid
//  src_gray       in   N_SRC*DATA_W   per-source pixel, source i at [i*DATA_W +: DATA_W]
//  filt_vsync/href out 1              to filter per_img_vsync/href
//  filt_gray      out  DATA_W         to filter per_img_gray
//  post_vsync/href in  1              from filter post_img_vsync/href
//  post_gray      in   DATA_W         from filter post_img_gray
//  dst_vsync/href out  N_SRC          per-source filtered frame-valid/line-valid
//  dst_gray       out  N_SRC*DATA_W   per-source filtered pixel
//  owner          out  $clog2(N_SRC)  index of current frame owner
//  busy           out  1              state != IDLE
//  err_proto      out  1              1-cycle pulse: ungranted source raised vsync
//  timeout        out  1              1-cycle pulse: drain watchdog fired (0 if macro off)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; round-robin pointer so source 0 wins first.
//  - FSM: IDLE -> GRANT when any src_req; winner = first requester after last owner (round robin); owner latched.
//  - GRANT: src_gnt[owner]=1; src_vsync[owner] rise -> STREAM; src_req[owner] drop -> IDLE, pointer unchanged.
//  - STREAM: src_gnt held; filt_* = registered copy of src_*[owner] (1-cycle latency); src_vsync[owner] fall -> DRAIN, gnt drops.
//  - DRAIN: filt_* forced 0; wait post_vsync rise then fall; on fall -> IDLE, pointer := owner.
//  - Return path (GRANT/STREAM/DRAIN): dst_*[owner] = registered post_* (1-cycle latency); all other dst lanes 0.
//  - Total source->dst latency = filter latency + 2 cycles.
//  - Simultaneous requests resolved only by round robin; same-cycle src_req rise and drain completion: new grant next cycle.
//  - Next grant never issued before DRAIN completes (filter line buffers must be empty).
//  - Ungranted src_vsync rising edge (per-source edge detect) -> err_proto pulse; its data ignored.
//  - Reset asserted mid-frame: immediate return to reset state; partial frame discarded, filter sees vsync=0.
// CONFIGURATION
//  FRAME_TIMEOUT_EN defined: cycle counter runs in DRAIN, cleared on entry; reaching TIMEOUT_CYCLES -> timeout pulse,
//   dst lanes zeroed, IDLE, pointer := owner.
//  Not defined: no counter, timeout tied 0, DRAIN waits indefinitely.
// STRUCTURE
//  img_arb_pkg: typedef enum logic[1:0] {IDLE,GRANT,STREAM,DRAIN} arb_state_t; OWNER_W localparam function.
//  Sub-module rr_pick: combinational round-robin picker (req vector, last pointer -> one-hot + index).
// TESTING (8x4 frames, filter model with fixed 20-cycle latency)
//  - Only src0 requests -> gnt[0] next cycle; frame passes; dst0 matches filtered reference, dst1 all 0.
//  - src0,src1 request same cycle, 3 frames each -> grants 0,1,0,1,0,1; no gnt while busy.
//  - src1 raises vsync without grant during src0 frame -> err_proto one pulse, filt_gray never equals src1 data.
//  - src1 drops req in GRANT -> IDLE, next grant still src1 when re-requested, no vsync to filter.
//  - rst_n low 3 cycles mid-STREAM -> all outputs 0, busy 0; next frame from src0 completes correctly.
//  - FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=64, filter post_vsync stuck high -> timeout pulse 64 cycles into DRAIN, IDLE.

Source files
------------

// File: rtl/img_arb_pkg.sv
// rtl/img_arb_pkg.sv - shared types and helpers for the frame arbiter
package img_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, STREAM, DRAIN} arb_state_t;

  // Owner index width; a single source still needs one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img_frame_arbiter_rr_pick.sv
// rtl/img_frame_arbiter_rr_pick.sv - combinational round-robin picker starting after the last owner
module rr_pick
  import img_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = owner_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);

  logic found;
  int   pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last_i) + k) % N;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = W'(pos);
      end
    end
  end

endmodule

// File: rtl/img_frame_arbiter.sv
// rtl/img_frame_arbiter.sv - whole-frame round-robin sharing of one filter; FRAME_TIMEOUT_EN adds a drain watchdog
module img_frame_arbiter
  import img_arb_pkg::*;
#(
  parameter int N_SRC          = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          src_req,
  output logic [N_SRC-1:0]          src_gnt,
  input  logic [N_SRC-1:0]          src_vsync,
  input  logic [N_SRC-1:0]          src_href,
  input  logic [N_SRC*DATA_W-1:0]   src_gray,
  output logic                      filt_vsync,
  output logic                      filt_href,
  output logic [DATA_W-1:0]         filt_gray,
  input  logic                      post_vsync,
  input  logic                      post_href,
  input  logic [DATA_W-1:0]         post_gray,
  output logic [N_SRC-1:0]          dst_vsync,
  output logic [N_SRC-1:0]          dst_href,
  output logic [N_SRC*DATA_W-1:0]   dst_gray,
  output logic [owner_w(N_SRC)-1:0] owner,
  output logic                      busy,
  output logic                      err_proto,
  output logic                      timeout
);

  localparam int OW = owner_w(N_SRC);

  arb_state_t               state_q, state_d;
  logic [OW-1:0]            owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [N_SRC-1:0]         gvec_q, gvec_d, pick_gnt;
  logic [N_SRC-1:0]         vs_prev_q, vs_rise;
  logic                     post_prev_q, post_rise, post_fall;
  logic                     seen_q, seen_d;
  logic                     filt_vsync_q, filt_vsync_d, filt_href_q, filt_href_d;
  logic [DATA_W-1:0]        filt_gray_q, filt_gray_d;
  logic [N_SRC-1:0]         dst_vsync_q, dst_vsync_d, dst_href_q, dst_href_d;
  logic [N_SRC*DATA_W-1:0]  dst_gray_q, dst_gray_d;
  logic                     err_q, err_d;
  logic                     own_vsync, own_href;
  logic [DATA_W-1:0]        own_gray;
  logic                     tmo_fire;

  rr_pick #(.N(N_SRC), .W(OW)) u_pick (
    .req_i  (src_req),
    .last_i (ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign own_vsync = src_vsync[owner_q];
  assign own_href  = src_href[owner_q];
  assign own_gray  = src_gray[int'(owner_q)*DATA_W +: DATA_W];
  assign vs_rise   = src_vsync & ~vs_prev_q;
  assign post_rise = post_vsync & ~post_prev_q;
  assign post_fall = ~post_vsync & post_prev_q;

`ifdef FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || state_q != DRAIN) tmo_cnt_q <= '0;
    else                            tmo_cnt_q <= tmo_cnt_q + CW'(1);
  end

  assign tmo_fire = (state_q == DRAIN) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog disabled: DRAIN waits for the filter indefinitely.
  assign tmo_fire = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    src_gnt = '0;
    if (state_q == GRANT || state_q == STREAM) src_gnt = gvec_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      ptr_q        <= OW'(N_SRC - 1);
      gvec_q       <= '0;
      vs_prev_q    <= '0;
      post_prev_q  <= 1'b0;
      seen_q       <= 1'b0;
      filt_vsync_q <= 1'b0;
      filt_href_q  <= 1'b0;
      filt_gray_q  <= '0;
      dst_vsync_q  <= '0;
      dst_href_q   <= '0;
      dst_gray_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      gvec_q       <= gvec_d;
      vs_prev_q    <= src_vsync;
      post_prev_q  <= post_vsync;
      seen_q       <= seen_d;
      filt_vsync_q <= filt_vsync_d;
      filt_href_q  <= filt_href_d;
      filt_gray_q  <= filt_gray_d;
      dst_vsync_q  <= dst_vsync_d;
      dst_href_q   <= dst_href_d;
      dst_gray_q   <= dst_gray_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gvec_d  = gvec_q;
    // The filtered frame may start before the source frame ends, so its rise is tracked from GRANT on.
    seen_d  = seen_q | (post_rise & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (|src_req) begin
          state_d = GRANT;
          owner_d = pick_idx;
          gvec_d  = pick_gnt;
          seen_d  = 1'b0;
        end
      end
      GRANT: begin
        if (!src_req[owner_q])     state_d = IDLE;
        else if (vs_rise[owner_q]) state_d = STREAM;
      end
      STREAM: begin
        if (!own_vsync) state_d = DRAIN;
      end
      DRAIN: begin
        if ((seen_q && post_fall) || tmo_fire) begin
          state_d = IDLE;
          ptr_d   = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    filt_vsync_d = 1'b0;
    filt_href_d  = 1'b0;
    filt_gray_d  = '0;
    if (state_d == STREAM) begin
      filt_vsync_d = own_vsync;
      filt_href_d  = own_href;
      filt_gray_d  = own_gray;
    end

    dst_vsync_d = '0;
    dst_href_d  = '0;
    dst_gray_d  = '0;
    if (state_q != IDLE && !tmo_fire) begin
      dst_vsync_d[owner_q]                        = post_vsync;
      dst_href_d[owner_q]                         = post_href;
      dst_gray_d[int'(owner_q)*DATA_W +: DATA_W]  = post_gray;
    end

    err_d = |(vs_rise & ~src_gnt);
  end

  assign filt_vsync = filt_vsync_q;
  assign filt_href  = filt_href_q;
  assign filt_gray  = filt_gray_q;
  assign dst_vsync  = dst_vsync_q;
  assign dst_href   = dst_href_q;
  assign dst_gray   = dst_gray_q;
  assign owner      = owner_q;
  assign busy       = (state_q != IDLE);
  assign err_proto  = err_q;
  assign timeout    = tmo_fire;

endmodule

// File: tb/tb_img_frame_arbiter.sv
// tb/tb_img_frame_arbiter.sv - scoreboard bench for img_frame_arbiter with a 20-cycle filter model
module tb_img_frame_arbiter;

  localparam int N   = 2;
  localparam int DW  = 8;
  localparam int LAT = 20;
`ifdef FRAME_TIMEOUT_EN
  localparam int TMO = 64;
`else
  localparam int TMO = 4096;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    src_req = '0, src_vsync = '0, src_href = '0;
  logic [N*DW-1:0] src_gray = '0;
  logic [N-1:0]    src_gnt, dst_vsync, dst_href;
  logic [N*DW-1:0] dst_gray;
  logic            filt_vsync, filt_href, post_vsync, post_href;
  logic [DW-1:0]   filt_gray, post_gray;
  logic [0:0]      owner;
  logic            busy, err_proto, timeout;
  logic [63:0]     all_out;

  always #5 clk = ~clk;

  img_frame_arbiter #(.N_SRC(N), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_gnt(src_gnt),
    .src_vsync(src_vsync), .src_href(src_href), .src_gray(src_gray),
    .filt_vsync(filt_vsync), .filt_href(filt_href), .filt_gray(filt_gray),
    .post_vsync(post_vsync), .post_href(post_href), .post_gray(post_gray),
    .dst_vsync(dst_vsync), .dst_href(dst_href), .dst_gray(dst_gray),
    .owner(owner), .busy(busy), .err_proto(err_proto), .timeout(timeout)
  );

  assign all_out = 64'({src_gnt, filt_vsync, filt_href, filt_gray, dst_vsync, dst_href,
                        dst_gray, owner, busy, err_proto, timeout});

  // Filter model: fixed latency, pixel inverted; optional stuck-high post_vsync.
  logic [DW+1:0] pipe [LAT];
  logic          stuck = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= {filt_vsync, filt_href, ~filt_gray};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign post_vsync = stuck | pipe[LAT-1][DW+1];
  assign post_href  = pipe[LAT-1][DW];
  assign post_gray  = pipe[LAT-1][DW-1:0];

  int total = 0, bad = 0, cyc = 0;
  logic [7:0] q0[$], q1[$];
  int gq[$];
  int err_cnt = 0, tmo_cnt = 0, tmo_cyc = 0, drain_cyc = 0, filt_ee = 0;
  int first_src = -1, first_dst = -1;
  bit filt_vs_seen = 0, dst1_vs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel or a new grant.
  initial begin
    logic [N-1:0] prev_gnt;
    logic prev_busy;
    int e;
    prev_gnt = '0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_gnt = '0;
        prev_busy = 1'b0;
      end else begin
        if (dst_href[0]) begin
          if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL dst0_unexpected act=%0h exp=none", dst_gray[7:0]);
          end else chk("dst0_pix", 64'(dst_gray[7:0]), 64'(q0.pop_front()));
        end
        if (dst_href[1]) begin
          if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL dst1_unexpected act=%0h exp=none", dst_gray[15:8]);
          end else chk("dst1_pix", 64'(dst_gray[15:8]), 64'(q1.pop_front()));
        end
        if (src_gnt != '0 && prev_gnt == '0) begin
          if (gq.size() == 0) begin
            total++; bad++;
            $display("FAIL gnt_unexpected act=%0h exp=none", src_gnt);
          end else begin
            e = gq.pop_front();
            chk("gnt_owner", 64'(src_gnt), 64'(1) << e);
            chk("gnt_after_idle", 64'(prev_busy), 64'(0));
          end
        end
        if (prev_gnt != '0 && src_gnt == '0 && busy) drain_cyc = cyc;
        if (filt_href && filt_gray == 8'hEE) filt_ee++;
        if (filt_vsync) filt_vs_seen = 1;
        if (dst_vsync[1]) dst1_vs = 1;
        if (dst_href[0] && first_dst < 0) first_dst = cyc;
        if (err_proto) err_cnt++;
        if (timeout) begin
          tmo_cnt++;
          tmo_cyc = cyc;
        end
        prev_gnt = src_gnt;
        prev_busy = busy;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    src_req = '0; src_vsync = '0; src_href = '0; src_gray = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_gnt(input int s, output bit ok);
    int b = 0;
    while (!src_gnt[s] && b < 3000) begin
      tick();
      b++;
    end
    ok = src_gnt[s];
    if (!ok) begin
      total++; bad++;
      $display("FAIL gnt_wait src=%0d act=0 exp=1", s);
    end
  endtask

  task automatic wait_idle(input string nm);
    int b = 0;
    while (busy && b < 3000) begin
      tick();
      b++;
    end
    chk(nm, 64'(busy), 64'(0));
  endtask

  // 8x4 frame: one lead cycle of vsync, 8 pixels per line, 2 blank cycles between lines.
  task automatic send_frame(input int s, input logic [7:0] base);
    logic [7:0] pix;
    src_vsync[s] = 1'b1;
    tick();
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) begin
        pix = base + 8'(l * 8 + p);
        src_href[s] = 1'b1;
        src_gray[s*DW +: DW] = pix;
        if (s == 0) q0.push_back(~pix);
        else        q1.push_back(~pix);
        if (first_src < 0) first_src = cyc;
        tick();
      end
      src_href[s] = 1'b0;
      src_gray[s*DW +: DW] = '0;
      tick();
      tick();
    end
    src_vsync[s] = 1'b0;
    tick();
  endtask

  task automatic run_src(input int s, input int n, input logic [7:0] base);
    bit ok;
    src_req[s] = 1'b1;
    for (int f = 0; f < n; f++) begin
      wait_gnt(s, ok);
      if (!ok) break;
      send_frame(s, base + 8'(f * 32));
      if (f == n - 1) src_req[s] = 1'b0;
      tick();
      tick();
    end
    src_req[s] = 1'b0;
  endtask

  task automatic spurious_src1();
    repeat (6) tick();
    src_vsync[1] = 1'b1;
    src_href[1] = 1'b1;
    src_gray[15:8] = 8'hEE;
    repeat (8) tick();
    src_vsync[1] = 1'b0;
    src_href[1] = 1'b0;
    src_gray[15:8] = 8'h00;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bit ok;
    int e0;
    int b;

    // Reset state
    repeat (2) tick();
    chk("reset_outputs", all_out, 64'(0));
    do_reset();

    // Single source: grant follows next cycle, lane 1 stays quiet, latency = 20 + 2
    first_src = -1; first_dst = -1; dst1_vs = 0;
    gq.push_back(0);
    run_src(0, 1, 8'h10);
    wait_idle("t1_idle");
    chk("t1_latency", 64'(first_dst - first_src), 64'(LAT + 2));
    chk("t1_dst1_quiet", 64'(dst1_vs), 64'(0));

    // Both sources, three frames each: strict alternation from source 0
    do_reset();
    for (int i = 0; i < 6; i++) gq.push_back(i % 2);
    fork
      run_src(0, 3, 8'h40);
      run_src(1, 3, 8'h80);
    join
    wait_idle("t2_idle");

    // Ungranted vsync from source 1 during a source 0 frame
    e0 = err_cnt; filt_ee = 0;
    gq.push_back(0);
    fork
      run_src(0, 1, 8'h10);
      spurious_src1();
    join
    wait_idle("t3_idle");
    chk("t3_err_pulses", 64'(err_cnt - e0), 64'(1));
    chk("t3_filt_clean", 64'(filt_ee), 64'(0));

    // Source 1 withdraws in GRANT: pointer stays on 0, so source 1 still wins the tie
    filt_vs_seen = 0;
    gq.push_back(1);
    src_req[1] = 1'b1;
    wait_gnt(1, ok);
    tick(); tick();
    src_req[1] = 1'b0;
    tick(); tick();
    chk("t4_drop_idle", 64'(busy), 64'(0));
    chk("t4_no_filt_vsync", 64'(filt_vs_seen), 64'(0));
    gq.push_back(1);
    gq.push_back(0);
    fork
      run_src(0, 1, 8'h20);
      run_src(1, 1, 8'h60);
    join
    wait_idle("t4_idle");

    // Reset mid-STREAM discards the partial frame
    e0 = err_cnt;
    gq.push_back(0);
    src_req[0] = 1'b1;
    wait_gnt(0, ok);
    src_vsync[0] = 1'b1;
    tick();
    for (int p = 0; p < 5; p++) begin
      src_href[0] = 1'b1;
      src_gray[7:0] = 8'(p + 1);
      tick();
    end
    rst_n = 1'b0;
    src_req = '0; src_vsync = '0; src_href = '0; src_gray = '0;
    repeat (3) tick();
    chk("t5_reset_outputs", all_out, 64'(0));
    rst_n = 1'b1;
    tick();
    chk("t5_busy_after", 64'(busy), 64'(0));
    gq.push_back(0);
    run_src(0, 1, 8'h30);
    wait_idle("t5_idle");
    chk("t5_no_err", 64'(err_cnt - e0), 64'(0));

`ifdef FRAME_TIMEOUT_EN
    // Stuck post_vsync: watchdog ends DRAIN on its 64th cycle
    do_reset();
    e0 = tmo_cnt;
    stuck = 1'b1;
    gq.push_back(0);
    run_src(0, 1, 8'h50);
    b = 0;
    while (busy && b < 500) begin
      tick();
      b++;
    end
    chk("t6_idle", 64'(busy), 64'(0));
    chk("t6_tmo_pulses", 64'(tmo_cnt - e0), 64'(1));
    chk("t6_tmo_delay", 64'(tmo_cyc - drain_cyc), 64'(TMO - 1));
    stuck = 1'b0;
    repeat (30) tick();
`else
    b = 0;
    chk("no_timeout", 64'(tmo_cnt), 64'(b));
`endif

    repeat (30) tick();
    chk("q0_drained", 64'(q0.size()), 64'(0));
    chk("q1_drained", 64'(q1.size()), 64'(0));
    chk("gq_drained", 64'(gq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
